// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: one-hot payout FSM encodings and coin values
// (0.5-yuan units). Also used by the coin-in controller.
package vend_pkg;

  localparam int PAY_ST_W = 7;

  localparam int IDLE_B   = 0;
  localparam int PAY1_B   = 1;
  localparam int WAIT1_B  = 2;
  localparam int PAY05_B  = 3;
  localparam int WAIT05_B = 4;
  localparam int DONE_B   = 5;
  localparam int ERR_B    = 6;

  typedef enum logic [PAY_ST_W-1:0] {
    ST_IDLE   = 7'b000_0001,
    ST_PAY1   = 7'b000_0010,
    ST_WAIT1  = 7'b000_0100,
    ST_PAY05  = 7'b000_1000,
    ST_WAIT05 = 7'b001_0000,
    ST_DONE   = 7'b010_0000,
    ST_ERR    = 7'b100_0000
  } pay_state_e;

  localparam int COIN05_VAL = 1;
  localparam int COIN1_VAL  = 2;

endpackage

// File: rtl/vend_ack_timer.sv
// Hopper acknowledge timer: cleared while a coin is being requested, counts idle
// WAIT cycles, and flags when the count reaches ACK_TIMEOUT-1.
module vend_ack_timer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/vend_coin_payout.sv
// Change payout FSM driving a two-tube (1 / 0.5 yuan) hopper, one coin per ack.
// Optional VEND_PAYOUT_STATS_EN adds an 8-bit wrapping count of acknowledged coins.
module vend_coin_payout
  import vend_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             hopper_empty1,
  input  logic             hopper_ack,
  output logic             coin1_out,
  output logic             coin05_out,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef VEND_PAYOUT_STATS_EN
  output logic [7:0]       coins_paid,
`endif
  output logic [AMT_W-1:0] rem_amount
);

  pay_state_e       r_state;
  logic [AMT_W-1:0] r_rem;
  logic             w_in_wait;
  logic             w_timeout;
  logic [AMT_W-1:0] w_rem_after1;
  logic [AMT_W-1:0] w_rem_after05;

  // Largest coin first; 1-yuan only when it cannot overshoot the remaining change.
  function automatic pay_state_e next_coin(input logic [AMT_W-1:0] r, input logic empty1);
    if (r >= AMT_W'(COIN1_VAL) && !empty1) return ST_PAY1;
    else if (r >= AMT_W'(COIN05_VAL))      return ST_PAY05;
    else                                   return ST_DONE;
  endfunction

  assign w_in_wait     = r_state[WAIT1_B] | r_state[WAIT05_B];
  assign w_rem_after1  = r_rem - AMT_W'(COIN1_VAL);
  assign w_rem_after05 = r_rem - AMT_W'(COIN05_VAL);

  vend_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state[PAY1_B] | r_state[PAY05_B]),
    .i_inc    (w_in_wait & ~hopper_ack & ~w_timeout),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_rem   <= req_amount;
            r_state <= next_coin(req_amount, hopper_empty1);
          end
        end
        ST_PAY1:  r_state <= ST_WAIT1;
        ST_PAY05: r_state <= ST_WAIT05;
        ST_WAIT1: begin
          if (hopper_ack) begin
            r_rem   <= w_rem_after1;
            r_state <= next_coin(w_rem_after1, hopper_empty1);
          end else if (w_timeout) begin
            r_state <= ST_ERR;
          end
        end
        ST_WAIT05: begin
          if (hopper_ack) begin
            r_rem   <= w_rem_after05;
            r_state <= next_coin(w_rem_after05, hopper_empty1);
          end else if (w_timeout) begin
            r_state <= ST_ERR;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef VEND_PAYOUT_STATS_EN
  logic [7:0] r_coins_paid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coins_paid <= '0;
    end else if (w_in_wait && hopper_ack) begin
      r_coins_paid <= r_coins_paid + 8'd1;
    end
  end

  assign coins_paid = r_coins_paid;
`endif

  // Moore outputs straight from the one-hot state flops.
  assign req_ready  = r_state[IDLE_B];
  assign busy       = ~r_state[IDLE_B];
  assign coin1_out  = r_state[PAY1_B];
  assign coin05_out = r_state[PAY05_B];
  assign done       = r_state[DONE_B];
  assign err        = r_state[ERR_B];
  assign rem_amount = r_rem;

endmodule

// File: tb/tb_vend_coin_payout.sv
// Directed bench for vend_coin_payout: table of payout scenarios plus
// hand-written sequences for busy-time requests and reset mid-payout.
module tb_vend_coin_payout;

  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             hopper_empty1;
  logic             hopper_ack;
  logic             coin1_out;
  logic             coin05_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] rem_amount;
`ifdef VEND_PAYOUT_STATS_EN
  logic [7:0]       coins_paid;
`endif

  int checks = 0;
  int errors = 0;

  vend_coin_payout #(
    .AMT_W      (AMT_W),
    .ACK_TIMEOUT(8),
    .CNT_W      (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_amount   (req_amount),
    .req_ready    (req_ready),
    .hopper_empty1(hopper_empty1),
    .hopper_ack   (hopper_ack),
    .coin1_out    (coin1_out),
    .coin05_out   (coin05_out),
    .busy         (busy),
    .done         (done),
    .err          (err),
`ifdef VEND_PAYOUT_STATS_EN
    .coins_paid   (coins_paid),
`endif
    .rem_amount   (rem_amount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // emode: 0 = tube1 full, 1 = tube1 empty, 2 = tube1 empties with the first ack
  typedef struct {
    int         amt;
    int         emode;
    bit         ack_en;
    int         n1;
    int         n05;
    bit         dn;
    bit         er;
    int         rem;
    int         end_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    int  n1, n05, cd, end_cyc, order_bad, ended, acks;
    bit  seen05;
    int  d, e, r;
`ifdef VEND_PAYOUT_STATS_EN
    int  base;
    base = int'(coins_paid);
`endif
    n1 = 0; n05 = 0; cd = 0; end_cyc = -1; order_bad = 0; ended = 0; acks = 0;
    seen05 = 1'b0; d = 0; e = 0; r = -1;
    @(negedge clk);
    req_valid     = 1'b1;
    req_amount    = AMT_W'(v.amt);
    hopper_empty1 = (v.emode == 1);
    hopper_ack    = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      hopper_ack = 1'b0;
      if (coin1_out) begin
        n1++;
        if (seen05) order_bad++;
      end
      if (coin05_out) begin
        n05++;
        seen05 = 1'b1;
      end
      if (done || err) begin
        d = int'(done); e = int'(err); r = int'(rem_amount);
        end_cyc = cyc; ended = 1;
        break;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          hopper_ack = 1'b1;
          acks++;
          if (v.emode == 2) hopper_empty1 = 1'b1;
        end
      end
      if ((coin1_out || coin05_out) && v.ack_en) cd = 2;
      @(negedge clk);
    end
    hopper_ack = 1'b0;
    check($sformatf("v%0d ended", idx), ended, 1);
    check($sformatf("v%0d coin1 count", idx), n1, v.n1);
    check($sformatf("v%0d coin05 count", idx), n05, v.n05);
    check($sformatf("v%0d done", idx), d, int'(v.dn));
    check($sformatf("v%0d err", idx), e, int'(v.er));
    check($sformatf("v%0d rem_amount", idx), r, v.rem);
    check($sformatf("v%0d end cycle", idx), end_cyc, v.end_cyc);
    check($sformatf("v%0d coin order", idx), order_bad, 0);
    @(negedge clk);
    check($sformatf("v%0d req_ready after", idx), int'(req_ready), 1);
    check($sformatf("v%0d busy after", idx), int'(busy), 0);
    check($sformatf("v%0d rem held", idx), int'(rem_amount), v.rem);
`ifdef VEND_PAYOUT_STATS_EN
    check($sformatf("v%0d coins_paid", idx), int'(coins_paid), (base + acks) % 256);
`endif
  endtask

  initial begin
    //          amt emode ack n1 n05 dn er rem end
    vecs[0] = '{3, 0, 1'b1, 1, 1, 1'b1, 1'b0, 0, 6};
    vecs[1] = '{0, 0, 1'b1, 0, 0, 1'b1, 1'b0, 0, 0};
    vecs[2] = '{4, 1, 1'b1, 0, 4, 1'b1, 1'b0, 0, 12};
    vecs[3] = '{5, 2, 1'b1, 1, 3, 1'b1, 1'b0, 0, 12};
    vecs[4] = '{6, 0, 1'b0, 1, 0, 1'b0, 1'b1, 6, 9};
    vecs[5] = '{7, 0, 1'b1, 3, 1, 1'b1, 1'b0, 0, 12};
    vecs[6] = '{2, 1, 1'b1, 0, 2, 1'b1, 1'b0, 0, 6};
    vecs[7] = '{1, 0, 1'b1, 0, 1, 1'b1, 1'b0, 0, 3};

    rst_n = 1'b0; req_valid = 1'b0; req_amount = '0;
    hopper_empty1 = 1'b0; hopper_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset req_ready", int'(req_ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset rem_amount", int'(rem_amount), 0);
    check("reset pulses", int'({coin1_out, coin05_out, done, err}), 0);
`ifdef VEND_PAYOUT_STATS_EN
    check("reset coins_paid", int'(coins_paid), 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Request arriving while waiting for a 1-yuan ack must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_amount = 4'd2; hopper_empty1 = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("busyreq coin1 pulse", int'(coin1_out), 1);
    @(negedge clk);
    check("busyreq req_ready in WAIT1", int'(req_ready), 0);
    check("busyreq busy in WAIT1", int'(busy), 1);
    req_valid = 1'b1; req_amount = 4'd5;
    @(negedge clk);
    req_valid = 1'b0; hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    check("busyreq done", int'(done), 1);
    check("busyreq rem", int'(rem_amount), 0);
    @(negedge clk);
    check("busyreq idle after", int'(busy), 0);
    @(negedge clk);
    check("busyreq no restart", int'({busy, coin1_out, coin05_out}), 0);
    check("busyreq rem stays", int'(rem_amount), 0);

    // Asynchronous reset in the middle of a 0.5-yuan wait.
    @(negedge clk);
    req_valid = 1'b1; req_amount = 4'd1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst coin05 pulse", int'(coin05_out), 1);
    @(negedge clk);
    check("rst in WAIT05 busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst outputs low", int'({coin1_out, coin05_out, done, err, busy}), 0);
    check("rst req_ready", int'(req_ready), 1);
    check("rst rem_amount", int'(rem_amount), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst stays idle", int'({busy, done, err}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
